// File: rtl/wptr_full_sync.sv
// Write-domain controller for an asynchronous FIFO.
//
// Combines three functions in the w_clk domain:
//   - an N-stage synchronizer for the Gray-coded read pointer
//   - the write pointer, kept as a binary counter with a registered Gray copy
//   - registered full, almost-full and fill-level flags
// It also keeps two sticky error bits. w_overflow records a write that was
// dropped because the FIFO was full. rptr_err records a synchronized read
// pointer that moved by more than one Gray bit between samples.
//
// Ports:
//   w_clk          write-domain clock
//   rst_n          synchronous active-low reset
//   w_en           write request; accepted only when w_full is low
//   rptr           Gray read pointer from the read domain (asynchronous)
//   waddr          RAM write address (low AW bits of the binary write pointer)
//   wptr           registered Gray write pointer, sent to the read domain
//   w_full         FIFO full (registered)
//   w_almost_full  fill level >= AF_THRESH (registered)
//   w_level        fill level 0..DEPTH as seen from the write domain (registered)
//   w_overflow     sticky: a write was attempted while full
//   rptr_err       sticky: synchronized rptr jumped by more than one bit
module wptr_full_sync #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = DEPTH - 2,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          w_en,
  input  logic [AW:0]   rptr,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr,
  output logic          w_full,
  output logic          w_almost_full,
  output logic [AW:0]   w_level,
  output logic          w_overflow,
  output logic          rptr_err
);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("AF_THRESH must lie in 1..DEPTH");
  end

  localparam logic [AW:0] AfThresh = (AW + 1)'(AF_THRESH);

  // ---------------------------------------------------------------------------
  // Read-pointer synchronizer. Plain flop chain: nothing may sit between stages.
  // ---------------------------------------------------------------------------
  logic [AW:0] sync_q [SYNC_STAGES];

  always_ff @(posedge w_clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [AW:0] rptr_s;
  logic [AW:0] rbin_s;

  assign rptr_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int unsigned i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(rptr_s >> i);
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer and flags.
  // ---------------------------------------------------------------------------
  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wptr_q, wgray_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        af_q, af_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [AW:0] rptr_s_prev_q;
  logic        chk_arm_q;
  logic        accept;
  logic [AW:0] rptr_delta;
  logic        multi_bit;

  // Gate on the registered full flag so accept never depends on this cycle's rptr_s.
  assign accept  = w_en & ~full_q;
  assign wbin_d  = wbin_q + {{AW{1'b0}}, accept};
  assign wgray_d = wbin_d ^ (wbin_d >> 1);

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code that is "top two bits inverted, the rest equal".
  assign full_d  = (wgray_d == {~rptr_s[AW:AW-1], rptr_s[AW-2:0]});

  // Modular subtraction; stays in 0..DEPTH while rptr is well formed.
  assign level_d = wbin_d - rbin_s;
  assign af_d    = (level_d >= AfThresh);

  // A dropped write (w_en while full) marks overflow until reset.
  assign ovf_d   = ovf_q | (w_en & full_q);

  // x & (x - 1) clears the lowest set bit, so a nonzero result means two or more
  // bits changed. chk_arm_q holds the check off for the first edge after reset.
  assign rptr_delta = rptr_s ^ rptr_s_prev_q;
  assign multi_bit  = |(rptr_delta & (rptr_delta - 1'b1));
  assign err_d      = err_q | (chk_arm_q & multi_bit);

  always_ff @(posedge w_clk) begin
    if (!rst_n) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      af_q          <= 1'b0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      rptr_s_prev_q <= '0;
      chk_arm_q     <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wgray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      af_q          <= af_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
      rptr_s_prev_q <= rptr_s;
      chk_arm_q     <= 1'b1;
    end
  end

  assign waddr         = wbin_q[AW-1:0];
  assign wptr          = wptr_q;
  assign w_full        = full_q;
  assign w_almost_full = af_q;
  assign w_level       = level_q;
  assign w_overflow    = ovf_q;
  assign rptr_err      = err_q;

endmodule

// File: doc/wptr_full_sync.md
Name: wptr_full_sync

Overview:
Write-domain controller for the async FIFO. It merges three functions: a parametrised N-stage synchronizer for the Gray read pointer, the write-pointer binary/Gray counter, and registered full, almost-full and fill-level flags. It also adds sticky overflow and Gray-integrity error reporting, which the basic two-flop synchronizer lacks. It sits between the write interface and the dual-port RAM write port, in the w_clk domain.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4; AW = $clog2(DEPTH).
SYNC_STAGES, 2, flops in the rptr synchronizer chain; >= 2.
AF_THRESH, DEPTH-2, fill level at or above which w_almost_full asserts; 1..DEPTH.

Ports:
w_clk  input  1  write-domain clock.
rst_n  input  1  reset, synchronous and active-low.
w_en  input  1  write request.
rptr  input  AW+1  Gray read pointer from the read domain (asynchronous).
waddr  output  AW  RAM write address.
wptr  output  AW+1  registered Gray write pointer, sent to the read domain.
w_full  output  1  FIFO full; registered.
w_almost_full  output  1  level >= AF_THRESH; registered.
w_level  output  AW+1  fill level 0..DEPTH, as seen from the write domain; registered.
w_overflow  output  1  sticky: a write was attempted while full.
rptr_err  output  1  sticky: synchronized rptr changed by more than one bit between consecutive samples.

Behaviour:
- Single clock w_clk. Reset is synchronous and active-low.
- While rst_n=0, at each edge: all sync stages, rptr_s_prev, wbin, wptr, w_full, w_almost_full, w_level, w_overflow and rptr_err are cleared to 0. w_en is ignored.
- Reset mid-operation has the same effect: pointers return to 0 and sticky bits clear.
- Sync chain:
  - stage[0] <= rptr; stage[i] <= stage[i-1].
  - rptr_s = stage[SYNC_STAGES-1].
  - No logic is allowed between stages.
- rbin_s = Gray-to-binary of rptr_s (combinational).
- Accept rule:
  - accept = w_en & ~w_full, using the registered w_full.
  - wbin_next = wbin + accept, modulo 2^(AW+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Registered updates each edge:
  - wbin <= wbin_next; wptr <= wgray_next.
  - waddr = wbin[AW-1:0].
- Full:
  - w_full <= (wgray_next == {~rptr_s[AW:AW-1], rptr_s[AW-2:0]}).
  - Full therefore asserts on the same edge that accepts the DEPTH-th outstanding write. There is no extra cycle of latency.
- Level:
  - w_level <= (wbin_next - rbin_s) modulo 2^(AW+1).
  - Its value is always within 0..DEPTH.
- Almost-full: w_almost_full <= ((wbin_next - rbin_s) >= AF_THRESH).
- Latency:
  - An rptr change reaches rptr_s after SYNC_STAGES edges.
  - Flags reflect it on edge SYNC_STAGES+1.
  - Flags are pessimistic during this window: full may stay high, but full never deasserts early.
- Overflow: if w_en=1 and w_full=1, the write is dropped (wbin and waddr unchanged) and w_overflow <= 1. It holds until reset.
- Simultaneous write and rptr advance: both apply within one computation; level_next reflects both.
- Integrity check:
  - rptr_s_prev <= rptr_s every edge.
  - If popcount(rptr_s ^ rptr_s_prev) > 1, rptr_err <= 1, sticky until reset.
  - The check is suppressed on the first edge after rst_n rises.
- Wrap-around: wbin and the Gray pointers wrap from 2^(AW+1)-1 to 0 naturally. The MSB toggle distinguishes full from empty, so there is no false full at wrap.

Test Plan:
1. Reset: hold rst_n=0 for 3 edges with w_en=1 and rptr=5'b00000 -> all outputs 0 and waddr=0. Release -> outputs remain 0 while w_en=0.
2. Fill (DEPTH=16, rptr=0): 16 back-to-back writes -> waddr counts 0..15 then 0.
   - w_almost_full rises on the 14th accept edge (level=14).
   - w_full rises on the 16th accept edge, with w_level=16 and wptr=5'b11000.
3. Overflow: from full, pulse w_en for 2 cycles -> wptr stays 5'b11000 and waddr stays 0. w_overflow=1 from the next edge and stays 1 after w_en drops.
4. Sync latency: from full, drive rptr=5'b00001 (Gray 1) -> w_full=1 for 2 more edges, then 0 on the 3rd edge with w_level=15 (SYNC_STAGES=2). Repeat with SYNC_STAGES=3 -> deasserts on the 4th edge.
5. Wrap: 40 writes with the bench advancing Gray rptr 1 entry behind -> wptr passes 5'b10000 (bin 31) to 5'b00000 (bin 0) and w_full never asserts. w_level matches the model every cycle.
6. Integrity: after reset, step rptr 5'b00000 -> 5'b00011 -> rptr_err=1 on edge 3 (SYNC_STAGES+1). Legal single-bit steps afterwards do not clear it; only rst_n=0 does.
